nf_rx_axis_upsizer: RTL and testbench
=====================================

# nf_rx_axis_upsizer

Parametrised ingress adapter between a MAC receive stream and the 256-bit NetFPGA datapath. It packs narrow MAC-side AXI-Stream beats into wide datapath beats and stamps NetFPGA `tuser` metadata on every output beat: running byte length, source port and destination port. It generalises the fixed-port, fixed-width interface glue to any power-of-two width ratio and to runtime-configurable port codes. It sits directly between the per-port MAC RX FIFO and the input arbiter.

## Interface
Parameters:
- C_S_AXIS_DATA_WIDTH, 64: input data width. Multiple of 8.
- C_M_AXIS_DATA_WIDTH, 256: output data width. Ratio R = M/S is a power of two, 1..8.
- C_M_AXIS_TUSER_WIDTH, 128: output tuser width, at least 32.
- C_DEFAULT_VALUE_ENABLE, 1: selects the port-code source.
  - 1: use the parameter port codes.
  - 0: use `src_port_cfg` / `dst_port_cfg`.
- C_DEFAULT_SRC_PORT, 8'h01: source-port one-hot code.
- C_DEFAULT_DST_PORT, 8'h00: destination-port code.

Ports:
- axi_aclk  in  1  sole clock; all logic on its rising edge.
- axi_aresetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  S  MAC-side data; byte 0 in bits [7:0].
- s_axis_tstrb  in  S/8  byte enables; contiguous from LSB.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tdata  out  M  packed data.
- m_axis_tstrb  out  M/8  packed byte enables.
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  metadata.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  last beat of packet.
- src_port_cfg  in  8  runtime source-port code.
- dst_port_cfg  in  8  runtime destination-port code.
- stats_clear  in  1  synchronous clear for the statistics counters (macro only).
- pkt_count  out  32  packets forwarded (macro only).
- byte_count  out  32  bytes forwarded (macro only).

## Operation
- Input handshake: an input beat is accepted when `s_axis_tvalid && s_axis_tready`.
- Lane placement: the accepted beat goes into accumulator lane `lane`, which occupies bits [lane*S +: S]. Lane 0 is the LSB.
- Flush condition: the accumulator flushes into the output register when `lane == R-1` or `s_axis_tlast`.
  - On a flush, `lane` returns to 0 and the accumulator clears.
  - Otherwise `lane` increments.
- Unfilled lanes of a flushed beat carry tdata 0 and tstrb 0.
- Byte length: `len` is a 16-bit running count. It adds popcount(tstrb) on every accepted beat and saturates at 16'hFFFF.
  - `len` resets to 0 after the tlast flush.
  - A beat with tstrb all 0 adds 0 but still occupies its lane.
- Port latching: on the first accepted beat of a packet, the block latches the port codes (parameters or cfg inputs, per C_DEFAULT_VALUE_ENABLE). They are held for the whole packet, so a cfg change mid-packet takes effect on the next packet.
- tuser layout, valid on every output beat:
  - [15:0] = `len` including the flushed beat, so the last beat carries the total packet length.
  - [23:16] = source port.
  - [31:24] = destination port.
  - All remaining bits are 0.
- Output `m_axis_tlast` equals the `s_axis_tlast` that caused the flush.

## Timing
- Reset values: every output and all internal state are 0, except `s_axis_tready`, which is 1 after reset. `lane` = 0.
- `s_axis_tready` = `!m_axis_tvalid || m_axis_tready`. It is a combinational function of output state only and never depends on `s_axis_tvalid`.
- Latency: `m_axis_tvalid` rises on the cycle after the flushing beat is accepted.
- Output hold: while `m_axis_tvalid && !m_axis_tready`, all m_axis signals stay stable and no input is accepted.
- Back-to-back: a flush in the same cycle as an output handshake reloads the output register with no bubble.
- Throughput: one output beat per R input beats at full rate.
- Tlast on lane 0 produces a one-lane output beat one cycle later.
- Reset asserted mid-packet: the partial packet is discarded. The first beat after reset is treated as the start of a packet.

## Configuration
- `NF_RX_STATS_EN` defined:
  - `pkt_count` increments by 1 on each output handshake with tlast.
  - `byte_count` adds that beat's tuser[15:0] on the same handshakes.
  - Both counters wrap modulo 2^32.
  - `stats_clear` zeroes both counters. If a clear and a counted event occur in the same cycle, the result is the event's contribution only (1 / len).
- `NF_RX_STATS_EN` undefined: the counter logic is absent, `pkt_count` and `byte_count` are tied to 0, and `stats_clear` is ignored.

## Test plan
- Reset, then check all outputs are 0 and `s_axis_tready` = 1.
- S=64, M=256, 64-byte packet with all tstrb 0xFF, sink always ready. Expect:
  - two output beats, each with tstrb all ones;
  - tuser[15:0] = 32 then 64, tlast only on the second beat;
  - tuser[23:16] = 8'h01.
- 68-byte packet (last input beat tstrb 0x0F). Expect:
  - the third output beat has tstrb = 32'h0000000F and zero data in lanes 1-3;
  - tuser[15:0] = 68.
- Sink ready held low for 5 cycles during the second output beat. Expect:
  - m_axis signals stable across the stall;
  - `s_axis_tready` = 0 throughout;
  - no beat lost or duplicated.
- C_DEFAULT_VALUE_ENABLE=0, `src_port_cfg` changed from 8'h04 to 8'h40 mid-packet. Expect tuser[23:16] = 8'h04 for the current packet and 8'h40 for the next.
- With `NF_RX_STATS_EN`: send 3 packets of 60 bytes, then `stats_clear` coincident with the tlast handshake of a 64-byte packet. Expect counters 3/180 before the clear and 1/64 after it.

Source files
------------

// File: rtl/nf_rx_axis_upsizer.sv
// Packs narrow MAC RX AXI-Stream beats into wide NetFPGA beats and stamps tuser {dst, src, len}.
// Define NF_RX_STATS_EN to build the packet/byte statistics counters.
module nf_rx_axis_upsizer #(
    parameter int         C_S_AXIS_DATA_WIDTH    = 64,
    parameter int         C_M_AXIS_DATA_WIDTH    = 256,
    parameter int         C_M_AXIS_TUSER_WIDTH   = 128,
    parameter int         C_DEFAULT_VALUE_ENABLE = 1,
    parameter logic [7:0] C_DEFAULT_SRC_PORT     = 8'h01,
    parameter logic [7:0] C_DEFAULT_DST_PORT     = 8'h00
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              m_axis_tlast,
    input  logic [7:0]                        src_port_cfg,
    input  logic [7:0]                        dst_port_cfg,
    input  logic                              stats_clear,
    output logic [31:0]                       pkt_count,
    output logic [31:0]                       byte_count
);

    localparam int S  = C_S_AXIS_DATA_WIDTH;
    localparam int M  = C_M_AXIS_DATA_WIDTH;
    localparam int SB = S / 8;
    localparam int MB = M / 8;
    localparam int R  = M / S;
    localparam int LW = (R > 1) ? $clog2(R) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(R - 1);
    localparam bit USE_DEFAULTS = (C_DEFAULT_VALUE_ENABLE != 32'sd0);

    function automatic logic [15:0] popcount(input logic [SB-1:0] v);
        logic [15:0] n;
        n = 16'd0;
        for (int i = 0; i < SB; i++) begin
            n = n + {15'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

    logic [LW-1:0] lane_r;
    logic [M-1:0]  acc_data_r;
    logic [MB-1:0] acc_strb_r;
    logic [15:0]   len_r;
    logic          in_pkt_r;
    logic [7:0]    src_r;
    logic [7:0]    dst_r;

    logic [M-1:0]  m_data_r;
    logic [MB-1:0] m_strb_r;
    logic [31:0]   m_user_r;
    logic          m_valid_r;
    logic          m_last_r;

    logic          ready_s;
    logic          accept_s;
    logic          flush_s;
    logic [M-1:0]  acc_data_s;
    logic [MB-1:0] acc_strb_s;
    logic [15:0]   len_next_s;
    logic [7:0]    src_s;
    logic [7:0]    dst_s;
    logic [31:0]   user_s;

    assign ready_s       = !m_valid_r || m_axis_tready;
    assign s_axis_tready = ready_s;
    assign accept_s      = s_axis_tvalid && ready_s;
    assign flush_s       = accept_s && ((lane_r == LAST_LANE) || s_axis_tlast);
    assign len_next_s    = sat_add(len_r, popcount(s_axis_tstrb));

    // Port codes: fresh source on the first beat of a packet, latched copy afterwards
    always_comb begin
        src_s = src_r;
        dst_s = dst_r;
        if (in_pkt_r) begin
            src_s = src_r;
            dst_s = dst_r;
        end else if (USE_DEFAULTS) begin
            src_s = C_DEFAULT_SRC_PORT;
            dst_s = C_DEFAULT_DST_PORT;
        end else begin
            src_s = src_port_cfg;
            dst_s = dst_port_cfg;
        end
    end

    // Accumulator with the incoming beat merged into the current lane
    always_comb begin
        acc_data_s = acc_data_r;
        acc_strb_s = acc_strb_r;
        acc_data_s[int'(lane_r) * S +: S]  = s_axis_tdata;
        acc_strb_s[int'(lane_r) * SB +: SB] = s_axis_tstrb;
    end

    // Metadata for the beat being flushed; length includes that beat
    always_comb begin
        user_s        = 32'd0;
        user_s[15:0]  = len_next_s;
        user_s[23:16] = src_s;
        user_s[31:24] = dst_s;
    end

    // Input side: lane pointer, accumulator, running length and packet port latch
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            lane_r     <= '0;
            acc_data_r <= '0;
            acc_strb_r <= '0;
            len_r      <= 16'd0;
            in_pkt_r   <= 1'b0;
            src_r      <= 8'd0;
            dst_r      <= 8'd0;
        end else if (accept_s) begin
            if (flush_s) begin
                lane_r     <= '0;
                acc_data_r <= '0;
                acc_strb_r <= '0;
            end else begin
                lane_r     <= lane_r + LW'(1'b1);
                acc_data_r <= acc_data_s;
                acc_strb_r <= acc_strb_s;
            end
            if (s_axis_tlast) begin
                len_r    <= 16'd0;
                in_pkt_r <= 1'b0;
            end else begin
                len_r    <= len_next_s;
                in_pkt_r <= 1'b1;
            end
            src_r <= src_s;
            dst_r <= dst_s;
        end
    end

    // Output register: reload on flush (even during a handshake), otherwise drain on ready
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            m_data_r  <= '0;
            m_strb_r  <= '0;
            m_user_r  <= 32'd0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
        end else if (flush_s) begin
            m_data_r  <= acc_data_s;
            m_strb_r  <= acc_strb_s;
            m_user_r  <= user_s;
            m_valid_r <= 1'b1;
            m_last_r  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            m_valid_r <= 1'b0;
        end
    end

    assign m_axis_tdata  = m_data_r;
    assign m_axis_tstrb  = m_strb_r;
    assign m_axis_tvalid = m_valid_r;
    assign m_axis_tlast  = m_last_r;

    // Upper tuser bits are reserved and always zero
    always_comb begin
        m_axis_tuser       = '0;
        m_axis_tuser[31:0] = m_user_r;
    end

`ifdef NF_RX_STATS_EN
    logic [31:0] pkt_count_r;
    logic [31:0] byte_count_r;
    logic        last_hs_s;

    assign last_hs_s = m_valid_r && m_axis_tready && m_last_r;

    // Counters: a clear coincident with a counted packet keeps only that packet
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pkt_count_r  <= 32'd0;
            byte_count_r <= 32'd0;
        end else if (stats_clear) begin
            pkt_count_r  <= last_hs_s ? 32'd1 : 32'd0;
            byte_count_r <= last_hs_s ? {16'd0, m_user_r[15:0]} : 32'd0;
        end else if (last_hs_s) begin
            pkt_count_r  <= pkt_count_r + 32'd1;
            byte_count_r <= byte_count_r + {16'd0, m_user_r[15:0]};
        end
    end

    assign pkt_count  = pkt_count_r;
    assign byte_count = byte_count_r;
`else
    logic unused_stats_s;
    assign unused_stats_s = stats_clear;
    assign pkt_count      = 32'd0;
    assign byte_count     = 32'd0;
`endif

endmodule

// File: tb/tb_nf_rx_axis_upsizer.sv
// Bench for nf_rx_axis_upsizer: directed + randomized traffic checked against a packet-level model.
// Two instances share the stimulus: parameter port codes and runtime cfg port codes.
`timescale 1ns/1ps
module tb_nf_rx_axis_upsizer;

    localparam int S  = 64;
    localparam int M  = 256;
    localparam int R  = M / S;
    localparam int TU = 128;
`ifdef NF_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [7:0]  src;
        logic [7:0]  dst;
    } in_beat_t;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  strb;
        logic [15:0]  len;
        logic [7:0]   src;
        logic [7:0]   dst;
        logic         last;
    } out_beat_t;

    logic          clk;
    logic          rst_n;
    logic [63:0]   s_tdata;
    logic [7:0]    s_tstrb;
    logic          s_tvalid;
    logic          s_tlast;
    logic          m_ready;
    logic [7:0]    src_cfg;
    logic [7:0]    dst_cfg;
    logic          stats_clear;

    logic          a_tready, a_tvalid, a_tlast;
    logic [255:0]  a_tdata;
    logic [31:0]   a_tstrb;
    logic [TU-1:0] a_tuser;
    logic [31:0]   a_pkt, a_byte;
    logic          b_tready, b_tvalid, b_tlast;
    logic [255:0]  b_tdata;
    logic [31:0]   b_tstrb;
    logic [TU-1:0] b_tuser;
    logic [31:0]   b_pkt, b_byte;

    nf_rx_axis_upsizer dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(a_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(a_tdata), .m_axis_tstrb(a_tstrb), .m_axis_tuser(a_tuser),
        .m_axis_tvalid(a_tvalid), .m_axis_tready(m_ready), .m_axis_tlast(a_tlast),
        .src_port_cfg(src_cfg), .dst_port_cfg(dst_cfg), .stats_clear(stats_clear),
        .pkt_count(a_pkt), .byte_count(a_byte)
    );

    nf_rx_axis_upsizer #(.C_DEFAULT_VALUE_ENABLE(0)) dut_cfg (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(b_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(b_tdata), .m_axis_tstrb(b_tstrb), .m_axis_tuser(b_tuser),
        .m_axis_tvalid(b_tvalid), .m_axis_tready(m_ready), .m_axis_tlast(b_tlast),
        .src_port_cfg(src_cfg), .dst_port_cfg(dst_cfg), .stats_clear(stats_clear),
        .pkt_count(b_pkt), .byte_count(b_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    in_beat_t    beat_q[$];
    in_beat_t    acc_q[$];
    out_beat_t   exp_q[$];
    logic [15:0] obs_len[$];
    logic        obs_last[$];
    logic [7:0]  obs_src[$];
    bit          in_pkt;
    int unsigned byte_sum;
    logic [7:0]  pkt_src, pkt_dst;
    logic [31:0] m_pkt, m_byte;
    int          out_total;
    int          stall_target;
    int          stall_cnt;
    bit          arm_clear, clear_now, rand_ready, dense_valid;
    int          tests_run;
    int          tests_failed;

    task automatic check_eq(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Reference: collect R accepted beats (or up to tlast) into one wide beat
    task automatic model_accept(input in_beat_t b);
        out_beat_t e;
        if (!in_pkt) begin
            pkt_src = b.src;
            pkt_dst = b.dst;
            in_pkt  = 1'b1;
        end
        acc_q.push_back(b);
        byte_sum += $countones(b.strb);
        if (acc_q.size() == R || b.last) begin
            e.data = '0;
            e.strb = '0;
            foreach (acc_q[i]) begin
                e.data[i*S +: S] = acc_q[i].data;
                e.strb[i*8 +: 8] = acc_q[i].strb;
            end
            e.len  = (byte_sum > 65535) ? 16'hFFFF : 16'(byte_sum);
            e.src  = pkt_src;
            e.dst  = pkt_dst;
            e.last = b.last;
            exp_q.push_back(e);
            acc_q.delete();
            if (b.last) begin
                in_pkt   = 1'b0;
                byte_sum = 0;
            end
        end
    endtask

    task automatic add_pkt(input int nbytes, input logic [7:0] src_first, input logic [7:0] src_rest,
                           input bit holes);
        in_beat_t b;
        int nbeats;
        int rem;
        nbeats = (nbytes == 0) ? 1 : (nbytes + 7) / 8;
        for (int i = 0; i < nbeats; i++) begin
            rem    = nbytes - i * 8;
            b.data = {$urandom, $urandom};
            b.strb = (rem >= 8) ? 8'hFF : ((rem <= 0) ? 8'h00 : (8'hFF >> (8 - rem)));
            b.last = (i == nbeats - 1);
            if (holes && !b.last && $urandom_range(0, 7) == 0) b.strb = 8'h00;
            b.src  = (i == 0) ? src_first : src_rest;
            b.dst  = 8'($urandom);
            beat_q.push_back(b);
        end
    endtask

    task automatic cycle();
        out_beat_t     e;
        logic [TU-1:0] ua, ub;
        bit            in_hs, out_hs, exp_valid;
        stats_clear = clear_now;
        clear_now   = 1'b0;
        if (beat_q.size() != 0 && (dense_valid || $urandom_range(0, 3) != 0)) begin
            s_tvalid = 1'b1;
            s_tdata  = beat_q[0].data;
            s_tstrb  = beat_q[0].strb;
            s_tlast  = beat_q[0].last;
            src_cfg  = beat_q[0].src;
            dst_cfg  = beat_q[0].dst;
        end else begin
            s_tvalid = 1'b0;
            s_tdata  = {$urandom, $urandom};
            s_tstrb  = 8'($urandom);
            s_tlast  = 1'($urandom);
            src_cfg  = 8'($urandom);
            dst_cfg  = 8'($urandom);
        end
        if (stall_target >= 0 && stall_cnt == 0 && exp_q.size() != 0 && out_total == stall_target) begin
            stall_cnt    = 5;
            stall_target = -1;
        end
        if (stall_cnt > 0) begin
            m_ready = 1'b0;
            stall_cnt--;
        end else begin
            m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        #1;
        exp_valid = (exp_q.size() != 0);
        check_eq("tvalid", a_tvalid, exp_valid);
        check_eq("cfg_tvalid", b_tvalid, exp_valid);
        check_eq("tready", a_tready, !exp_valid || m_ready);
        check_eq("cfg_tready", b_tready, !exp_valid || m_ready);
        if (exp_valid) begin
            ua = '0; ua[15:0] = exp_q[0].len; ua[23:16] = 8'h01; ua[31:24] = 8'h00;
            ub = '0; ub[15:0] = exp_q[0].len; ub[23:16] = exp_q[0].src; ub[31:24] = exp_q[0].dst;
            check_eq("tdata", a_tdata, exp_q[0].data);
            check_eq("tstrb", a_tstrb, exp_q[0].strb);
            check_eq("tlast", a_tlast, exp_q[0].last);
            check_eq("tuser", a_tuser, ua);
            check_eq("cfg_tdata", b_tdata, exp_q[0].data);
            check_eq("cfg_tuser", b_tuser, ub);
        end
        check_eq("pkt_count", a_pkt, STATS ? m_pkt : 32'd0);
        check_eq("byte_count", a_byte, STATS ? m_byte : 32'd0);
        check_eq("cfg_pkt_count", b_pkt, STATS ? m_pkt : 32'd0);
        in_hs  = s_tvalid && (!exp_valid || m_ready);
        out_hs = exp_valid && m_ready;
        if (arm_clear && out_hs && exp_q[0].last) begin
            stats_clear = 1'b1;
            arm_clear   = 1'b0;
        end
        if (stats_clear) begin
            m_pkt  = 32'd0;
            m_byte = 32'd0;
        end
        if (out_hs) begin
            e = exp_q.pop_front();
            out_total++;
            obs_len.push_back(a_tuser[15:0]);
            obs_last.push_back(a_tlast);
            obs_src.push_back(b_tuser[23:16]);
            if (e.last) begin
                m_pkt  += 32'd1;
                m_byte += {16'd0, e.len};
            end
        end
        if (in_hs) model_accept(beat_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((beat_q.size() != 0 || exp_q.size() != 0) && n < 20000) begin
            cycle();
            n++;
        end
        check_eq("drain_timeout", n < 20000, 1'b1);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        s_tvalid    = 1'b0;
        stats_clear = 1'b0;
        m_ready     = 1'b0;
        #3;
        check_eq("rst_tvalid", a_tvalid, 1'b0);
        check_eq("rst_tlast", a_tlast, 1'b0);
        check_eq("rst_tdata", a_tdata, 256'd0);
        check_eq("rst_tstrb", a_tstrb, 32'd0);
        check_eq("rst_tuser", a_tuser, 128'd0);
        check_eq("rst_tready", a_tready, 1'b1);
        check_eq("rst_cfg_tuser", b_tuser, 128'd0);
        check_eq("rst_pkt", a_pkt, 32'd0);
        check_eq("rst_byte", a_byte, 32'd0);
        beat_q.delete(); acc_q.delete(); exp_q.delete();
        in_pkt = 1'b0; byte_sum = 0; m_pkt = 32'd0; m_byte = 32'd0;
        stall_cnt = 0; stall_target = -1; arm_clear = 1'b0; clear_now = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic clear_obs();
        obs_len.delete();
        obs_last.delete();
        obs_src.delete();
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; out_total = 0;
        s_tdata = 64'd0; s_tstrb = 8'd0; s_tlast = 1'b0; src_cfg = 8'd0; dst_cfg = 8'd0;
        rand_ready = 1'b0; dense_valid = 1'b1;
        do_reset();

        // 64-byte packet, full rate
        clear_obs();
        add_pkt(64, 8'h04, 8'h04, 1'b0);
        drain();
        check_eq("p64_beats", obs_len.size(), 2);
        check_eq("p64_len0", obs_len[0], 16'd32);
        check_eq("p64_len1", obs_len[1], 16'd64);
        check_eq("p64_last0", obs_last[0], 1'b0);
        check_eq("p64_last1", obs_last[1], 1'b1);

        // 68-byte packet with a partial final beat
        clear_obs();
        add_pkt(68, 8'h02, 8'h02, 1'b0);
        drain();
        check_eq("p68_beats", obs_len.size(), 3);
        check_eq("p68_len", obs_len[2], 16'd68);

        // Sink stall during the second output beat
        clear_obs();
        stall_target = out_total + 1;
        add_pkt(64, 8'h01, 8'h01, 1'b0);
        drain();
        check_eq("stall_hit", stall_target, -1);
        check_eq("stall_beats", obs_len.size(), 2);

        // Runtime source port changes mid-packet
        clear_obs();
        add_pkt(64, 8'h04, 8'h40, 1'b0);
        add_pkt(40, 8'h40, 8'h40, 1'b0);
        drain();
        check_eq("cfg_src_p0b0", obs_src[0], 8'h04);
        check_eq("cfg_src_p0b1", obs_src[1], 8'h04);
        check_eq("cfg_src_p1", obs_src[2], 8'h40);

        // Statistics: three 60-byte packets, then clear coincident with a tlast handshake
        do_reset();
        for (int i = 0; i < 3; i++) add_pkt(60, 8'h01, 8'h01, 1'b0);
        drain();
        check_eq("stats_pkt3", a_pkt, STATS ? 32'd3 : 32'd0);
        check_eq("stats_byte180", a_byte, STATS ? 32'd180 : 32'd0);
        arm_clear = 1'b1;
        add_pkt(64, 8'h01, 8'h01, 1'b0);
        drain();
        check_eq("stats_clear_used", arm_clear, 1'b0);
        check_eq("stats_pkt1", a_pkt, STATS ? 32'd1 : 32'd0);
        check_eq("stats_byte64", a_byte, STATS ? 32'd64 : 32'd0);

        // Randomized traffic with backpressure and gaps
        rand_ready = 1'b1; dense_valid = 1'b0;
        for (int batch = 0; batch < 15; batch++) begin
            for (int p = 0; p < 10; p++) begin
                add_pkt($urandom_range(0, 200), 8'($urandom), 8'($urandom), 1'b1);
            end
            drain();
            if (batch % 4 == 1) begin
                clear_now = 1'b1;
                cycle();
            end
        end

        // Reset in the middle of a packet discards it
        rand_ready = 1'b0; dense_valid = 1'b1;
        add_pkt(200, 8'h11, 8'h11, 1'b0);
        repeat (10) cycle();
        do_reset();
        clear_obs();
        add_pkt(64, 8'h08, 8'h08, 1'b0);
        drain();
        check_eq("post_rst_beats", obs_len.size(), 2);
        check_eq("post_rst_len", obs_len[1], 16'd64);
        check_eq("post_rst_src", obs_src[0], 8'h08);

        // Length saturation on an oversized packet
        clear_obs();
        add_pkt(65600, 8'h01, 8'h01, 1'b0);
        drain();
        check_eq("sat_len", obs_len[obs_len.size() - 1], 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
